irq_src_conditioner: RTL
========================

Name: irq_src_conditioner

Overview:
Upstream neighbour of the RISC-V PLIC wrapper; drives its irq_sources vector.
- Synchronizes raw interrupt lines from accelerators and tiles into clk.
- Per source, either passes the level through or converts a rising edge into a sticky pending level. The PLIC runs every source in level mode.
- Pending bits are cleared by software over a small APB slave window that shares the PLIC's APB style.

Parameters:
NIRQ_SRCS, 30, number of interrupt sources; legal range 1..32 (elaboration error otherwise)
SYNC_STAGES, 2, synchronizer flop depth; legal range 2..4

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
irq_raw  in  NIRQ_SRCS  asynchronous raw interrupt lines
irq_sources  out  NIRQ_SRCS  conditioned level interrupts to the PLIC
cond_psel  in  1  APB select
cond_penable  in  1  APB enable
cond_pwrite  in  1  APB write
cond_paddr  in  32  APB address; only [7:0] decoded
cond_pwdata  in  32  APB write data
cond_prdata  out  32  APB read data
cond_pready  out  1  APB ready
cond_pslverr  out  1  APB error

Behaviour:
- Reset: one clock, synchronous, active-high.
  - All synchronizer flops, prev, pending, MODE, irq_sources, cond_prdata, cond_pready and cond_pslverr go to 0.
  - FSM goes to IDLE.
  - Reset mid-transfer abandons the transfer; no write is committed.
- Synchronizer: s = irq_raw delayed SYNC_STAGES flops; prev = s delayed 1 cycle; rise = s & ~prev.
- Per source i, within the same cycle:
  - clr[i] = committed W1C write to PENDING with pwdata[i]=1.
  - pend_d[i] = (pend_q[i] & ~clr[i]) | (MODE[i] & rise[i]). Set wins over a simultaneous clear.
  - irq_sources[i] is registered from MODE[i] ? pend_d[i] : s[i].
- Latency: an irq_raw edge appears on irq_sources after SYNC_STAGES+1 clk edges in both modes.
- Level mode: the output falls SYNC_STAGES+1 cycles after irq_raw falls. Pending holds 0.
- Edge mode: the output stays high until cleared, then falls on the cycle after the clearing write commits. A pulse shorter than one clk period may be lost; the source must hold its line for at least 2 cycles.
- Writing a MODE bit to a different value clears that source's pending bit in the same commit cycle, unless rise sets it that cycle.
- Register map (word offsets, paddr[1:0] ignored):
  - 0x00 MODE: RW, bits [NIRQ_SRCS-1:0]; 1 = edge, 0 = level.
  - 0x04 PENDING: read returns pend_q; write is W1C.
  - 0x08 RAW: RO, returns s; writes ignored, no error.
  - Unimplemented bits read 0.
  - Any other offset: pslverr=1, prdata=0, no side effect.
- APB FSM: IDLE, RESP.
  - IDLE -> RESP when psel&penable. The address, write flag and data are captured in that cycle.
  - In RESP: pready=1 for exactly one cycle. prdata and pslverr are registered and valid in that cycle. A write commits on the RESP clock edge. Next state is IDLE.
  - Result: exactly one wait state per transfer. pready is 0 in IDLE.
  - Back-to-back transfers are accepted; the next access phase is sampled from IDLE.

Optional Feature:
Macro IRQ_COND_MASK_EN.
- Defined:
  - Register 0x0C MASK, RW, reset all-ones.
  - irq_sources[i] = registered (MODE[i] ? pend_d[i] : s[i]) & MASK[i].
  - Pending still accumulates while masked, so an unmask exposes a held edge on the next cycle.
- Not defined: offset 0x0C returns pslverr=1 and no masking logic exists.

Decomposition:
- Package irq_src_conditioner_pkg holds:
  - offsets MODE_OFS=8'h00, PEND_OFS=8'h04, RAW_OFS=8'h08, MASK_OFS=8'h0C;
  - MAX_SRCS=32;
  - apb_state_t enum {IDLE, RESP}.
- One sub-module, irq_sync_bit: a parameterized SYNC_STAGES-deep flop chain with synchronous active-high reset, instantiated per source in a generate loop.

Test Plan:
- Reset, then read offsets 0x00/0x04/0x08: each returns 0 with pready on the second cycle and pslverr=0. irq_sources=0.
- Level mode: drive irq_raw[3]=1 for 10 cycles. irq_sources[3] rises 3 edges later, falls 3 edges after the drop, and PENDING reads 0.
- Edge mode: write MODE=0x1, pulse irq_raw[0] for 2 cycles. irq_sources[0] stays 1 and PENDING=0x1. Write PENDING=0x1, and irq_sources[0] reads 0 on the cycle after commit.
- Simultaneous set/clear: a W1C on bit 0 commits in the same cycle as rise[0]. Pending stays 1.
- Error path: access 0x10 (and 0x0C with the macro undefined) gives pslverr=1, prdata=0, and all registers unchanged. Assert rst during RESP of a MODE=0xFF write: MODE reads 0 afterward.
- With IRQ_COND_MASK_EN: write MASK=0xFFFFFFFE, edge on source 0. irq_sources[0]=0 and PENDING=0x1. Write MASK=0xFFFFFFFF, and irq_sources[0]=1 one cycle after commit.

Source files
------------

// File: rtl/irq_src_conditioner_pkg.sv
// irq_src_conditioner_pkg: register offsets, source limit and APB state type
package irq_src_conditioner_pkg;
  localparam logic [7:0] MODE_OFS = 8'h00;
  localparam logic [7:0] PEND_OFS = 8'h04;
  localparam logic [7:0] RAW_OFS = 8'h08;
  localparam logic [7:0] MASK_OFS = 8'h0C;
  localparam int MAX_SRCS = 32;
  typedef enum logic {IDLE, RESP} apb_state_t;
endpackage

// File: rtl/irq_sync_bit.sv
// irq_sync_bit: SYNC_STAGES-deep flop chain bringing one async line into clk
module irq_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] chain;
  always_ff @(posedge clk) chain <= rst ? '0 : {chain[SYNC_STAGES-2:0], d};
  assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/irq_src_conditioner.sv
// irq_src_conditioner: synchronizes raw irq lines, level/edge conditioning, APB W1C window
// Optional MASK register at 0x0C when IRQ_COND_MASK_EN is defined.
module irq_src_conditioner
  import irq_src_conditioner_pkg::*;
#(
  parameter int NIRQ_SRCS = 30,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NIRQ_SRCS-1:0] irq_raw,
  output logic [NIRQ_SRCS-1:0] irq_sources,
  input  logic                 cond_psel,
  input  logic                 cond_penable,
  input  logic                 cond_pwrite,
  input  logic [31:0]          cond_paddr,
  input  logic [31:0]          cond_pwdata,
  output logic [31:0]          cond_prdata,
  output logic                 cond_pready,
  output logic                 cond_pslverr
);
  if (NIRQ_SRCS < 1 || NIRQ_SRCS > MAX_SRCS) begin : g_bad_nirq
    $error("NIRQ_SRCS must be within 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be within 2..4");
  end
  logic [NIRQ_SRCS-1:0] s, prev, rise, mode_q, pend_q, pend_d, clr, lvl, out_d, wdata_q;
  apb_state_t state, state_d;
  logic [5:0] addr_q;
  logic wr_q, accept, commit, wr_mode, wr_pend;
  logic sel_mode, sel_pend, sel_raw, sel_mask, err_d;
  logic [31:0] rd_d;
  logic unused_bits;
  for (genvar i = 0; i < NIRQ_SRCS; i++) begin : g_sync
    irq_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .rst(rst), .d(irq_raw[i]), .q(s[i])
    );
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_d;
  always_comb state_d = (state == IDLE && cond_psel && cond_penable) ? RESP : IDLE;
  always_comb begin
    accept = state == IDLE && cond_psel && cond_penable;
    commit = state == RESP && wr_q;
    cond_pready = state == RESP;
  end
  assign sel_mode = cond_paddr[7:2] == MODE_OFS[7:2];
  assign sel_pend = cond_paddr[7:2] == PEND_OFS[7:2];
  assign sel_raw = cond_paddr[7:2] == RAW_OFS[7:2];
  assign err_d = !(sel_mode || sel_pend || sel_raw || sel_mask);
  assign wr_mode = commit && addr_q == MODE_OFS[7:2];
  assign wr_pend = commit && addr_q == PEND_OFS[7:2];
  assign unused_bits = ^{cond_paddr[31:8], cond_paddr[1:0], cond_pwdata};
  // Changing a source's mode drops any pending edge it held; a same-cycle rise still wins.
  always_comb begin
    rise = s & ~prev;
    clr = ({NIRQ_SRCS{wr_pend}} & wdata_q) | ({NIRQ_SRCS{wr_mode}} & (wdata_q ^ mode_q));
    pend_d = (pend_q & ~clr) | (mode_q & rise);
    lvl = (mode_q & pend_d) | (~mode_q & s);
  end
`ifdef IRQ_COND_MASK_EN
  logic [NIRQ_SRCS-1:0] mask_q;
  logic wr_mask;
  assign sel_mask = cond_paddr[7:2] == MASK_OFS[7:2];
  assign wr_mask = commit && addr_q == MASK_OFS[7:2];
  assign out_d = lvl & mask_q;
  always_ff @(posedge clk) mask_q <= rst ? '1 : wr_mask ? wdata_q : mask_q;
  always_comb begin
    rd_d = sel_mode ? 32'(mode_q) : sel_pend ? 32'(pend_q) : sel_raw ? 32'(s) : '0;
    if (sel_mask) rd_d = 32'(mask_q);
  end
`else
  assign sel_mask = 1'b0;
  assign out_d = lvl;
  always_comb rd_d = sel_mode ? 32'(mode_q) : sel_pend ? 32'(pend_q) : sel_raw ? 32'(s) : '0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
      mode_q <= '0;
      pend_q <= '0;
      irq_sources <= '0;
      cond_prdata <= '0;
      cond_pslverr <= 1'b0;
      addr_q <= '0;
      wr_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      prev <= s;
      pend_q <= pend_d;
      irq_sources <= out_d;
      cond_prdata <= accept ? rd_d : '0;
      cond_pslverr <= accept && err_d;
      if (accept) begin
        addr_q <= cond_paddr[7:2];
        wr_q <= cond_pwrite;
        wdata_q <= cond_pwdata[NIRQ_SRCS-1:0];
      end
      if (wr_mode) mode_q <= wdata_q;
    end
  end
endmodule
